// File: rtl/eic_input_conditioner_pkg.sv
// eic_input_conditioner_pkg: shared defaults for the interrupt input conditioner
package eic_input_conditioner_pkg;
  localparam int EIC_CHANNELS = 8;
  localparam int EIC_SYNC_STAGES = 2;
  localparam int EIC_FILTER_WIDTH = 4;
endpackage

// File: rtl/eic_input_filter_channel.sv
// eic_input_filter_channel: one line's synchronizer, stability filter, change pulse and sticky glitch flag
module eic_input_filter_channel
  import eic_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = EIC_SYNC_STAGES,
  parameter int FILTER_WIDTH = EIC_FILTER_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    raw_in,
  input  logic [FILTER_WIDTH-1:0] filter_len,
  input  logic                    filter_en,
  input  logic                    glitch_clr,
  output logic                    signal,
  output logic                    changed,
  output logic                    glitch
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILTER_WIDTH-1:0] cnt_q, cnt_d;
  logic signal_q, signal_d, changed_q, changed_d, glitch_q, glitch_d;
  logic sync, mis, commit;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    sync = sync_q[SYNC_STAGES-1];
    mis = sync != signal_q;
    commit = mis && (!filter_en || cnt_q >= filter_len);
    signal_d = commit ? sync : signal_q;
    changed_d = commit;
    cnt_d = (filter_en && mis && !commit) ? cnt_q + 1'b1 : '0;
    glitch_d = (filter_en && !mis && cnt_q != '0) || (glitch_q && !glitch_clr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      signal_q <= 1'b0;
      changed_q <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      signal_q <= signal_d;
      changed_q <= changed_d;
      glitch_q <= glitch_d;
    end
  end
  assign signal = signal_q;
  assign changed = changed_q;
  assign glitch = glitch_q;
endmodule

// File: rtl/eic_input_conditioner.sv
// eic_input_conditioner: turns raw asynchronous interrupt lines into synchronized, glitch-filtered levels
module eic_input_conditioner
  import eic_input_conditioner_pkg::*;
#(
  parameter int CHANNELS = EIC_CHANNELS,
  parameter int SYNC_STAGES = EIC_SYNC_STAGES,
  parameter int FILTER_WIDTH = EIC_FILTER_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [CHANNELS-1:0]     raw_in,
  input  logic [FILTER_WIDTH-1:0] filter_len,
  input  logic [CHANNELS-1:0]     filter_en,
  input  logic [CHANNELS-1:0]     glitch_clr,
  output logic [CHANNELS-1:0]     signal,
  output logic [CHANNELS-1:0]     changed,
  output logic [CHANNELS-1:0]     glitch
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    eic_input_filter_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_WIDTH(FILTER_WIDTH)
    ) u_ch (
      .clk       (CLK),
      .rst       (RESET),
      .raw_in    (raw_in[g]),
      .filter_len(filter_len),
      .filter_en (filter_en[g]),
      .glitch_clr(glitch_clr[g]),
      .signal    (signal[g]),
      .changed   (changed[g]),
      .glitch    (glitch[g])
    );
  end
endmodule

// File: tb/tb_eic_input_conditioner.sv
// tb_eic_input_conditioner: directed self-checking bench for the interrupt input conditioner
module tb_eic_input_conditioner;
  logic CLK = 1'b0;
  logic RESET;
  logic [7:0] raw_in, filter_en, glitch_clr, signal, changed, glitch;
  logic [3:0] filter_len;
  int n_cmp = 0;
  int n_err = 0;
  eic_input_conditioner #(.CHANNELS(8), .SYNC_STAGES(2), .FILTER_WIDTH(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .raw_in    (raw_in),
    .filter_len(filter_len),
    .filter_en (filter_en),
    .glitch_clr(glitch_clr),
    .signal    (signal),
    .changed   (changed),
    .glitch    (glitch)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    RESET = 1'b1;
    raw_in = 8'hFF;
    filter_len = 4'd0;
    filter_en = 8'hFF;
    glitch_clr = 8'h00;
    #12 RESET = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      tick();
      n_cmp++;
      if (signal !== (k == 2 ? 8'hFF : 8'h00)) begin
        n_err++;
        $display("FAIL rst_first_signal k=%0d got %h exp %h", k, signal, (k == 2 ? 8'hFF : 8'h00));
      end
      n_cmp++;
      if (changed !== (k == 2 ? 8'hFF : 8'h00)) begin
        n_err++;
        $display("FAIL rst_first_changed k=%0d got %h exp %h", k, changed, (k == 2 ? 8'hFF : 8'h00));
      end
    end
    #1 RESET = 1'b1;
    #1;
    n_cmp++;
    if (signal !== 8'h00) begin
      n_err++;
      $display("FAIL rst_async_signal got %h exp 00", signal);
    end
    n_cmp++;
    if (changed !== 8'h00) begin
      n_err++;
      $display("FAIL rst_async_changed got %h exp 00", changed);
    end
    n_cmp++;
    if (glitch !== 8'h00) begin
      n_err++;
      $display("FAIL rst_async_glitch got %h exp 00", glitch);
    end
    #1 RESET = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      tick();
      n_cmp++;
      if (signal !== (k >= 2 ? 8'hFF : 8'h00)) begin
        n_err++;
        $display("FAIL rst_rel_signal k=%0d got %h exp %h", k, signal, (k >= 2 ? 8'hFF : 8'h00));
      end
      n_cmp++;
      if (changed !== (k == 2 ? 8'hFF : 8'h00)) begin
        n_err++;
        $display("FAIL rst_rel_changed k=%0d got %h exp %h", k, changed, (k == 2 ? 8'hFF : 8'h00));
      end
    end
  endtask
  task automatic test_latency;
    raw_in = 8'h00;
    repeat (4) tick();
    n_cmp++;
    if (signal !== 8'h00) begin
      n_err++;
      $display("FAIL lat_settle got %h exp 00", signal);
    end
    filter_len = 4'd3;
    filter_en = 8'h01;
    raw_in = 8'h01;
    for (int k = 0; k <= 6; k++) begin
      tick();
      n_cmp++;
      if (signal[0] !== (k >= 5) || changed[0] !== (k == 5)) begin
        n_err++;
        $display("FAIL lat_rise k=%0d got sig=%b chg=%b exp sig=%b chg=%b", k, signal[0], changed[0], k >= 5, k == 5);
      end
    end
    raw_in = 8'h00;
    for (int k = 0; k <= 6; k++) begin
      tick();
      n_cmp++;
      if (signal[0] !== (k < 5) || changed[0] !== (k == 5)) begin
        n_err++;
        $display("FAIL lat_fall k=%0d got sig=%b chg=%b exp sig=%b chg=%b", k, signal[0], changed[0], k < 5, k == 5);
      end
    end
  endtask
  task automatic test_glitch;
    filter_len = 4'd3;
    filter_en = 8'h02;
    raw_in[1] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 2) raw_in[1] = 1'b0;
      n_cmp++;
      if (signal[1] !== 1'b0 || glitch[1] !== (k >= 5)) begin
        n_err++;
        $display("FAIL glitch_short k=%0d got sig=%b gl=%b exp sig=0 gl=%b", k, signal[1], glitch[1], k >= 5);
      end
    end
    glitch_clr[1] = 1'b1;
    tick();
    glitch_clr[1] = 1'b0;
    n_cmp++;
    if (glitch[1] !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_clear got %b exp 0", glitch[1]);
    end
    raw_in[1] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 3) raw_in[1] = 1'b0;
      n_cmp++;
      if (signal[1] !== (k >= 5 && k < 9) || changed[1] !== (k == 5 || k == 9) || glitch[1] !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_long k=%0d got sig=%b chg=%b gl=%b exp sig=%b chg=%b gl=0",
                 k, signal[1], changed[1], glitch[1], k >= 5 && k < 9, k == 5 || k == 9);
      end
    end
  endtask
  task automatic test_clear_priority;
    raw_in[1] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 2) raw_in[1] = 1'b0;
    end
    n_cmp++;
    if (glitch[1] !== 1'b1) begin
      n_err++;
      $display("FAIL prio_first_glitch got %b exp 1", glitch[1]);
    end
    raw_in[1] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 2) raw_in[1] = 1'b0;
      glitch_clr[1] = (k == 4);
      n_cmp++;
      if (glitch[1] !== 1'b1) begin
        n_err++;
        $display("FAIL prio_set_wins k=%0d got %b exp 1", k, glitch[1]);
      end
    end
    glitch_clr = 8'hFF;
    tick();
    glitch_clr = 8'h00;
    n_cmp++;
    if (glitch !== 8'h00) begin
      n_err++;
      $display("FAIL prio_clear_all got %h exp 00", glitch);
    end
  endtask
  task automatic test_bypass;
    filter_en = 8'h00;
    filter_len = 4'd15;
    raw_in[2] = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 0) raw_in[2] = 1'b0;
      n_cmp++;
      if (signal[2] !== (k == 2) || changed[2] !== (k == 2 || k == 3) || glitch[2] !== 1'b0) begin
        n_err++;
        $display("FAIL bypass k=%0d got sig=%b chg=%b gl=%b exp sig=%b chg=%b gl=0",
                 k, signal[2], changed[2], glitch[2], k == 2, k == 2 || k == 3);
      end
    end
  endtask
  task automatic test_threshold;
    filter_len = 4'd10;
    filter_en = 8'h08;
    raw_in[3] = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      n_cmp++;
      if (signal[3] !== 1'b0) begin
        n_err++;
        $display("FAIL thr_hold k=%0d got %b exp 0", k, signal[3]);
      end
    end
    filter_len = 4'd2;
    tick();
    n_cmp++;
    if (signal[3] !== 1'b1 || changed[3] !== 1'b1 || glitch[3] !== 1'b0) begin
      n_err++;
      $display("FAIL thr_lower got sig=%b chg=%b gl=%b exp sig=1 chg=1 gl=0", signal[3], changed[3], glitch[3]);
    end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_clear_priority();
    test_bypass();
    test_threshold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
